// File: rtl/layer_output_serializer.sv
// Captures one parallel Q7.24 layer result vector and streams it out one neuron per beat, then
// pulses the argmax of the streamed values. Optional macro RELU_EN clamps negative words to 0 at capture.
module layer_output_serializer #(
    parameter int NEURONS = 2,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] data_inputs [NEURONS],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]         out_index,
    output logic                     out_last,
    output logic                     argmax_valid,
    output logic [IDX_W-1:0]         argmax_index,
    output logic signed [DATA_W-1:0] argmax_value
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);

    state_t                   state;
    logic signed [DATA_W-1:0] cap_q [NEURONS];
    logic [IDX_W-1:0]         cnt;
    logic [IDX_W-1:0]         cnt_nxt;
    logic signed [DATA_W-1:0] max_value;
    logic [IDX_W-1:0]         max_index;
    logic                     beat_acc;
    logic                     beat_gt;

    function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
`ifdef RELU_EN
        return (x < 0) ? '0 : x;
`else
        return x;
`endif
    endfunction

    assign cnt_nxt  = cnt + 1'b1;
    assign beat_acc = out_valid && out_ready;
    // Strict greater-than keeps the lower index on ties; beat 0 equals the seed so it never wins.
    assign beat_gt  = out_data > max_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            for (int i = 0; i < NEURONS; i++) cap_q[i] <= '0;
            cnt          <= '0;
            max_value    <= '0;
            max_index    <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_index    <= '0;
            out_last     <= 1'b0;
            argmax_valid <= 1'b0;
            argmax_index <= '0;
            argmax_value <= '0;
        end else begin
            argmax_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < NEURONS; i++) cap_q[i] <= relu(data_inputs[i]);
                        cnt       <= '0;
                        max_value <= relu(data_inputs[0]);
                        max_index <= '0;
                        out_valid <= 1'b1;
                        out_data  <= relu(data_inputs[0]);
                        out_index <= '0;
                        out_last  <= (NEURONS == 1);
                        in_ready  <= 1'b0;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (beat_acc) begin
                        if (beat_gt) begin
                            max_value <= out_data;
                            max_index <= cnt;
                        end
                        if (cnt == LAST_IDX) begin
                            // Result registers see the final beat in the same edge it is accepted.
                            argmax_valid <= 1'b1;
                            argmax_index <= beat_gt ? cnt : max_index;
                            argmax_value <= beat_gt ? out_data : max_value;
                            out_valid    <= 1'b0;
                            out_data     <= '0;
                            out_index    <= '0;
                            out_last     <= 1'b0;
                            in_ready     <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            cnt       <= cnt_nxt;
                            out_data  <= cap_q[cnt_nxt];
                            out_index <= cnt_nxt;
                            out_last  <= (cnt_nxt == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Randomized self-checking bench for layer_output_serializer (NEURONS=3 main instance, NEURONS=1 corner instance).
module tb_layer_output_serializer;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int IW = 2;

    typedef logic signed [DW-1:0] vec_t [N];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [DW-1:0] din [N];
    logic in_ready, out_valid, out_last, argmax_valid;
    logic signed [DW-1:0] out_data, argmax_value;
    logic [IW-1:0] out_index, argmax_index;

    logic in1_valid = 1'b0;
    logic out1_ready = 1'b1;
    logic signed [DW-1:0] din1 [1];
    logic in1_ready, out1_valid, out1_last, a1_valid;
    logic signed [DW-1:0] out1_data, a1_value;
    logic [0:0] out1_index, a1_index;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int prev_cap = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    layer_output_serializer #(.NEURONS(N), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_inputs(din), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .argmax_valid(argmax_valid), .argmax_index(argmax_index), .argmax_value(argmax_value)
    );

    layer_output_serializer #(.NEURONS(1), .DATA_W(DW), .IDX_W(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in1_valid), .in_ready(in1_ready),
        .data_inputs(din1), .out_valid(out1_valid), .out_ready(out1_ready),
        .out_data(out1_data), .out_index(out1_index), .out_last(out1_last),
        .argmax_valid(a1_valid), .argmax_index(a1_index), .argmax_value(a1_value)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [DW-1:0] mrelu(input logic signed [DW-1:0] x);
`ifdef RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    // First index holding the largest value.
    function automatic int model_argmax(input vec_t e);
        int b = 0;
        for (int k = 1; k < N; k++) if (e[k] > e[b]) b = k;
        return b;
    endfunction

    task automatic run_vector(input vec_t v, input int stall0, input int max_stall,
                              input bit busy, input bit b2b, input bit chk_period);
        vec_t e;
        int am;
        int s;
        for (int k = 0; k < N; k++) e[k] = mrelu(v[k]);
        am = model_argmax(e);
        chk("in_ready_before_capture", in_ready, 1);
        din = v;
        in_valid = 1'b1;
        tick();
        if (chk_period && prev_cap >= 0) chk("b2b_period", cyc - prev_cap, N + 1);
        prev_cap = cyc;
        for (int k = 0; k < N; k++) begin
            if (busy) begin
                in_valid = 1'b1;
                for (int j = 0; j < N; j++) din[j] = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            chk("beat_valid", out_valid, 1);
            chk("beat_data", out_data, e[k]);
            chk("beat_index", out_index, k);
            chk("beat_last", out_last, k == N - 1);
            chk("busy_in_ready", in_ready, 0);
            chk("no_pulse_mid", argmax_valid, 0);
            s = (k == 0 && stall0 > 0) ? stall0 : ((max_stall > 0) ? $urandom_range(max_stall, 0) : 0);
            out_ready = 1'b0;
            repeat (s) begin
                tick();
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, e[k]);
                chk("hold_index", out_index, k);
            end
            out_ready = 1'b1;
            tick();
        end
        chk("argmax_pulse", argmax_valid, 1);
        chk("argmax_index", argmax_index, am);
        chk("argmax_value", argmax_value, e[am]);
        chk("ready_with_pulse", in_ready, 1);
        chk("valid_drop", out_valid, 0);
        if (!b2b) begin
            in_valid = 1'b0;
            out_ready = 1'($urandom);
            tick();
            chk("pulse_one_cycle", argmax_valid, 0);
            chk("argmax_index_hold", argmax_index, am);
            chk("argmax_value_hold", argmax_value, e[am]);
            chk("idle_no_valid", out_valid, 0);
            out_ready = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        logic signed [DW-1:0] w;
        for (int j = 0; j < N; j++) din[j] = '0;
        din1[0] = '0;

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_argmax_valid", argmax_valid, 0);
        chk("rst_argmax_index", argmax_index, 0);
        chk("rst_argmax_value", argmax_value, 0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", in_ready, 1);

        // Single-neuron instance
        w = -32'sd12345;
        din1[0] = w;
        in1_valid = 1'b1;
        chk("n1_ready", in1_ready, 1);
        out1_ready = 1'b0;
        tick();
        in1_valid = 1'b0;
        chk("n1_valid", out1_valid, 1);
        chk("n1_last", out1_last, 1);
        chk("n1_index", out1_index, 0);
        chk("n1_data", out1_data, mrelu(w));
        out1_ready = 1'b1;
        tick();
        chk("n1_pulse", a1_valid, 1);
        chk("n1_am_index", a1_index, 0);
        chk("n1_am_value", a1_value, mrelu(w));

        // Directed vectors
        v[0] = 14680064; v[1] = 18874368; v[2] = 1048576;
        run_vector(v, 0, 0, 1'b0, 1'b0, 1'b0);
        run_vector(v, 3, 0, 1'b0, 1'b0, 1'b0);
        run_vector(v, 0, 2, 1'b1, 1'b0, 1'b0);
        v[0] = -8388608; v[1] = 4194304; v[2] = 4194304;
        run_vector(v, 0, 0, 1'b0, 1'b0, 1'b0);
        v[0] = -5; v[1] = -3; v[2] = -1;
        run_vector(v, 0, 1, 1'b0, 1'b0, 1'b0);
        v[0] = 7; v[1] = 7; v[2] = 7;
        run_vector(v, 0, 0, 1'b0, 1'b0, 1'b0);
        v[0] = 32'sh80000000; v[1] = 32'sh7fffffff; v[2] = 0;
        run_vector(v, 0, 0, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream after beat 0 is accepted
        v[0] = 100; v[1] = 200; v[2] = 300;
        din = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mid_beat0_valid", out_valid, 1);
        tick();
        chk("mid_beat1_index", out_index, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_pulse", argmax_valid, 0);
        chk("mid_rst_index", out_index, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_am_value", argmax_value, 0);
        repeat (N + 1) begin
            tick();
            chk("mid_no_pulse", argmax_valid, 0);
        end
        v[0] = 9; v[1] = -9; v[2] = 5;
        run_vector(v, 0, 0, 1'b0, 1'b0, 1'b0);

        // Back-to-back: capture coincides with each argmax pulse
        prev_cap = -1;
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < N; j++) v[j] = $urandom;
            run_vector(v, 0, 0, 1'b0, r != 4, 1'b1);
        end

        // Random vectors with ties, stalls and busy traffic
        for (int r = 0; r < 40; r++) begin
            for (int j = 0; j < N; j++)
                v[j] = (r % 3 == 0) ? ($signed($urandom_range(6, 0)) - 3) : $signed($urandom);
            run_vector(v, 0, 3, 1'($urandom), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
